// File: rtl/mem_req_queue_if.sv
// Core-side and cache-side signals of one per-core memory request queue.
// master = core pipeline plus cache port environment, slave = the queue itself.
interface mem_req_queue_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int CREG_ID_BITS = 3
);
  logic                    core_valid;
  logic                    core_rw;
  logic [ADDR_WIDTH-1:0]   core_addr;
  logic [DATA_WIDTH-1:0]   core_data;
  logic                    core_stall;
  logic                    resp_valid;
  logic                    resp_rw;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_accept;
  logic [ADDR_WIDTH-1:0]   addr_out;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    rw_out;
  logic                    valid_out;
  logic [CREG_ID_BITS-1:0] id_out;
  logic [DATA_WIDTH-1:0]   cache_data;
  logic [CREG_ID_BITS-1:0] cache_id;
  logic                    cache_ready;
  logic                    cache_stall;
  logic                    err_spurious;

  modport master (
    output core_valid, core_rw, core_addr, core_data, resp_accept,
           cache_data, cache_id, cache_ready, cache_stall,
    input  core_stall, resp_valid, resp_rw, resp_data,
           addr_out, data_out, rw_out, valid_out, id_out, err_spurious
  );

  modport slave (
    input  core_valid, core_rw, core_addr, core_data, resp_accept,
           cache_data, cache_id, cache_ready, cache_stall,
    output core_stall, resp_valid, resp_rw, resp_data,
           addr_out, data_out, rw_out, valid_out, id_out, err_spurious
  );
endinterface

// File: rtl/mem_req_queue.sv
// In-order issue / in-order retire request queue; slot index doubles as the cache request id.
// Issue one cycle after allocation, retire one cycle after the head's read returns; stalls when full.
module mem_req_queue #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int CREG_ID_BITS = 3
) (
  input logic           clk,
  input logic           reset,
  mem_req_queue_if.slave bus
);
  localparam int DEPTH = 1 << CREG_ID_BITS;
  localparam logic [CREG_ID_BITS:0] FULL_CNT = {1'b1, {CREG_ID_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_PEND   = 2'd1,
    S_ISSUED = 2'd2,
    S_DONE   = 2'd3
  } slot_state_t;

  slot_state_t             st     [DEPTH];
  logic                    rw_q   [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];

  logic [CREG_ID_BITS-1:0] tail;
  logic [CREG_ID_BITS-1:0] iss;
  logic [CREG_ID_BITS-1:0] head;
  logic [CREG_ID_BITS:0]   count;
  logic                    err;

  logic alloc;
  logic issue;
  logic ret_hit;
  logic retire;

  // Full check uses the registered count only, so a same-cycle retire never unblocks.
  assign bus.core_stall = (count == FULL_CNT) | ~reset;
  assign alloc          = bus.core_valid & ~bus.core_stall;

  assign bus.valid_out  = reset & (st[iss] == S_PEND);
  assign bus.addr_out   = reset ? addr_q[iss] : '0;
  assign bus.data_out   = reset ? data_q[iss] : '0;
  assign bus.rw_out     = reset & rw_q[iss];
  assign bus.id_out     = reset ? iss : '0;
  assign issue          = bus.valid_out & ~bus.cache_stall;

  assign ret_hit        = bus.cache_ready & (st[bus.cache_id] == S_ISSUED);

  assign bus.resp_valid = reset & (st[head] == S_DONE);
  assign bus.resp_rw    = reset & rw_q[head];
  assign bus.resp_data  = reset ? data_q[head] : '0;
  assign retire         = bus.resp_valid & bus.resp_accept;

  assign bus.err_spurious = err;

  // Alloc, issue, return and retire touch slots in FREE, PEND, ISSUED and DONE respectively,
  // so they always hit distinct slots and can all be applied in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        st[i]     <= S_FREE;
        rw_q[i]   <= 1'b0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      tail  <= '0;
      iss   <= '0;
      head  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (alloc) begin
        st[tail]     <= S_PEND;
        rw_q[tail]   <= bus.core_rw;
        addr_q[tail] <= bus.core_addr;
        data_q[tail] <= bus.core_data;
        tail         <= tail + 1'b1;
      end
      // Writes get no cache return, so they complete as soon as the cache takes them.
      if (issue) begin
        st[iss] <= rw_q[iss] ? S_DONE : S_ISSUED;
        iss     <= iss + 1'b1;
      end
      if (ret_hit) begin
        st[bus.cache_id]     <= S_DONE;
        data_q[bus.cache_id] <= bus.cache_data;
      end else if (bus.cache_ready) begin
        err <= 1'b1;
      end
      if (retire) begin
        st[head] <= S_FREE;
        head     <= head + 1'b1;
      end
      case ({alloc, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: reset, single read, out-of-order return, full/stall,
// wrap with mixed traffic, spurious return.
module tb_mem_req_queue;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IB = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_req_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CREG_ID_BITS(IB)) bus ();

  mem_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CREG_ID_BITS(IB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.core_valid  = 1'b0;
    bus.core_rw     = 1'b0;
    bus.core_addr   = '0;
    bus.core_data   = '0;
    bus.resp_accept = 1'b0;
    bus.cache_data  = '0;
    bus.cache_id    = '0;
    bus.cache_ready = 1'b0;
    bus.cache_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.core_valid = 1'b1;
    bus.core_rw    = rw;
    bus.core_addr  = addr;
    bus.core_data  = data;
    step();
    bus.core_valid = 1'b0;
  endtask

  task automatic ret(input logic [IB-1:0] id, input logic [DW-1:0] data);
    bus.cache_ready = 1'b1;
    bus.cache_id    = id;
    bus.cache_data  = data;
    step();
    bus.cache_ready = 1'b0;
  endtask

  task automatic accept();
    bus.resp_accept = 1'b1;
    step();
    bus.resp_accept = 1'b0;
  endtask

  int pending[$];
  int sent, issued, retired;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();

    // Reset held with a request pending: nothing may be taken or presented.
    bus.core_valid = 1'b1;
    bus.core_addr  = 32'h55;
    bus.core_data  = 32'h66;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("rst_core_stall", bus.core_stall, 1);
      check("rst_valid_out", bus.valid_out, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_addr_out", bus.addr_out, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_id_out", bus.id_out, 0);
      check("rst_resp_data", bus.resp_data, 0);
      check("rst_err", bus.err_spurious, 0);
    end
    bus.core_valid = 1'b0;
    reset = 1'b1;
    step();
    settle();
    check("post_rst_stall", bus.core_stall, 0);
    check("post_rst_no_alloc", bus.valid_out, 0);

    // Single read with fixed latency.
    do_reset();
    bus.core_valid = 1'b1;
    bus.core_rw    = 1'b0;
    bus.core_addr  = 32'h100;
    settle();
    check("t2_accept", bus.core_stall, 0);
    step();
    bus.core_valid = 1'b0;
    settle();
    check("t2_valid_c1", bus.valid_out, 1);
    check("t2_id_c1", bus.id_out, 0);
    check("t2_addr_c1", bus.addr_out, 32'h100);
    check("t2_rw_c1", bus.rw_out, 0);
    step();
    settle();
    check("t2_valid_c2", bus.valid_out, 0);
    step();
    step();
    step();
    bus.cache_ready = 1'b1;
    bus.cache_id    = 3'd0;
    bus.cache_data  = 32'hDEADBEEF;
    settle();
    check("t2_resp_c5", bus.resp_valid, 0);
    step();
    bus.cache_ready = 1'b0;
    settle();
    check("t2_resp_c6", bus.resp_valid, 1);
    check("t2_resp_data", bus.resp_data, 32'hDEADBEEF);
    check("t2_resp_rw", bus.resp_rw, 0);
    accept();
    settle();
    check("t2_retired", bus.resp_valid, 0);

    // Out-of-order returns, in-order retirement.
    do_reset();
    req(1'b0, 32'h200, 32'h0);
    settle();
    check("t3_id_a", bus.id_out, 0);
    req(1'b0, 32'h204, 32'h0);
    settle();
    check("t3_id_b", bus.id_out, 1);
    req(1'b0, 32'h208, 32'h0);
    settle();
    check("t3_id_c", bus.id_out, 2);
    step();
    settle();
    check("t3_all_issued", bus.valid_out, 0);
    ret(3'd2, 32'hCCCC0002);
    settle();
    check("t3_wait_after_c", bus.resp_valid, 0);
    ret(3'd0, 32'hAAAA0000);
    settle();
    check("t3_valid_after_a", bus.resp_valid, 1);
    check("t3_data_a", bus.resp_data, 32'hAAAA0000);
    ret(3'd1, 32'hBBBB0001);
    settle();
    check("t3_data_a_hold", bus.resp_data, 32'hAAAA0000);
    accept();
    settle();
    check("t3_valid_b", bus.resp_valid, 1);
    check("t3_data_b", bus.resp_data, 32'hBBBB0001);
    accept();
    settle();
    check("t3_data_c", bus.resp_data, 32'hCCCC0002);
    accept();
    settle();
    check("t3_empty", bus.resp_valid, 0);

    // Fill under cache stall, then drain issue.
    do_reset();
    bus.cache_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.core_valid = 1'b1;
      bus.core_rw    = 1'b0;
      bus.core_addr  = 32'h1000 + 32'(i * 4);
      settle();
      check("t4_core_stall", bus.core_stall, (i == 8) ? 1 : 0);
      if (i > 0) begin
        check("t4_hold_valid", bus.valid_out, 1);
        check("t4_hold_id", bus.id_out, 0);
        check("t4_hold_addr", bus.addr_out, 32'h1000);
      end
      step();
    end
    bus.core_valid = 1'b0;
    settle();
    check("t4_full", bus.core_stall, 1);
    bus.cache_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t4_issue_valid", bus.valid_out, 1);
      check("t4_issue_id", bus.id_out, 64'(i));
      check("t4_issue_addr", bus.addr_out, 64'(32'h1000 + 32'(i * 4)));
      step();
      settle();
    end
    check("t4_issue_done", bus.valid_out, 0);
    ret(3'd0, 32'h77);
    settle();
    check("t4_head_done", bus.resp_valid, 1);
    check("t4_head_data", bus.resp_data, 32'h77);
    bus.resp_accept = 1'b1;
    bus.core_valid  = 1'b1;
    bus.core_addr   = 32'h9999;
    check("t4_retire_no_unblock", bus.core_stall, 1);
    step();
    bus.resp_accept = 1'b0;
    settle();
    check("t4_unblocked", bus.core_stall, 0);
    check("t4_next_head_busy", bus.resp_valid, 0);
    bus.core_valid = 1'b0;

    // Wrap with alternating write/read, random accept, random return order.
    do_reset();
    sent = 0;
    issued = 0;
    retired = 0;
    pending.delete();
    for (int cyc = 0; cyc < 600 && retired < 20; cyc++) begin
      bus.core_valid  = (sent < 20);
      bus.core_rw     = (sent % 2 == 0);
      bus.core_addr   = 32'h3000 + 32'(sent * 4);
      bus.core_data   = 32'h5000 + 32'(sent);
      bus.cache_stall = ($urandom_range(0, 3) == 0);
      bus.resp_accept = $urandom_range(0, 1);
      bus.cache_ready = 1'b0;
      if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
        int idx;
        int sq;
        idx = $urandom_range(0, pending.size() - 1);
        sq  = pending[idx];
        pending.delete(idx);
        bus.cache_ready = 1'b1;
        bus.cache_id    = 3'(sq % 8);
        bus.cache_data  = 32'hA000 + 32'(sq);
      end
      settle();
      check("t5_core_stall", bus.core_stall, ((sent - retired) == 8) ? 1 : 0);
      if (bus.core_valid && !bus.core_stall) sent++;
      if (bus.valid_out && !bus.cache_stall) begin
        check("t5_issue_id", bus.id_out, 64'(issued % 8));
        check("t5_issue_addr", bus.addr_out, 64'(32'h3000 + 32'(issued * 4)));
        check("t5_issue_rw", bus.rw_out, (issued % 2 == 0) ? 1 : 0);
        if (issued % 2 == 1) pending.push_back(issued);
        issued++;
      end
      if (bus.resp_valid && bus.resp_accept) begin
        check("t5_retire_rw", bus.resp_rw, (retired % 2 == 0) ? 1 : 0);
        if (retired % 2 == 1) check("t5_retire_data", bus.resp_data, 64'(32'hA000 + 32'(retired)));
        retired++;
      end
      step();
    end
    idle_inputs();
    settle();
    check("t5_all_retired", 64'(retired), 20);
    check("t5_no_err", bus.err_spurious, 0);
    check("t5_empty_valid", bus.valid_out, 0);
    check("t5_empty_resp", bus.resp_valid, 0);

    // Spurious return to a free slot.
    ret(3'd5, 32'hBAD);
    settle();
    check("t6_err_set", bus.err_spurious, 1);
    check("t6_no_resp", bus.resp_valid, 0);
    check("t6_no_issue", bus.valid_out, 0);
    check("t6_not_stalled", bus.core_stall, 0);
    step();
    step();
    settle();
    check("t6_err_sticky", bus.err_spurious, 1);
    req(1'b0, 32'h4000, 32'h0);
    settle();
    check("t6_next_valid", bus.valid_out, 1);
    check("t6_next_id", bus.id_out, 4);
    check("t6_next_addr", bus.addr_out, 32'h4000);
    do_reset();
    settle();
    check("t6_err_cleared", bus.err_spurious, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
